// File: rtl/exec_complete_arbiter.sv
// ---------------------------------------------------------------------------
// exec_complete_arbiter
//   Collects finished results from NUM_UNITS execution units and grants one
//   per cycle onto a single registered common-data-bus (CDB) slot that feeds
//   the ROB. Each unit holds valid and stable data until it sees a one-cycle
//   canGo pulse. The ROB applies backpressure through robStall_i.
//
//   Optional build macro:
//     EXEC_ARB_FIXED_PRI_EN  defined   -> fixed priority, lowest index wins,
//                                         no rotating pointer.
//                            undefined -> round-robin (default).
//
// Ports
//   clk_i           clock
//   reset_i         synchronous, active-high reset
//   unitValid_i     per-unit "result ready"
//   unitVal_i       per-unit 64-bit result, unit k at [64k+63:64k]
//   unitTag_i       per-unit ROB tag, packed the same way
//   unitCommands_i  per-unit 10-bit command field, packed
//   unitFlags_i     per-unit 4-bit flags, packed
//   canGo_o         one-hot accept pulse back to the granted unit
//   robStall_i      ROB cannot take the CDB slot this cycle
//   cdbValid_o      CDB slot holds a result
//   cdbVal_o        CDB result value
//   cdbTag_o        CDB ROB tag
//   cdbCommands_o   CDB command field
//   cdbFlags_o      CDB flags
//   cdbUnit_o       index of the unit that produced the CDB result
// ---------------------------------------------------------------------------
module exec_complete_arbiter #(
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int NUM_UNITS  = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_UNITS-1:0]            unitValid_i,
  input  logic [NUM_UNITS*64-1:0]         unitVal_i,
  input  logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i,
  input  logic [NUM_UNITS*10-1:0]         unitCommands_i,
  input  logic [NUM_UNITS*4-1:0]          unitFlags_i,
  output logic [NUM_UNITS-1:0]            canGo_o,
  input  logic                            robStall_i,
  output logic                            cdbValid_o,
  output logic [63:0]                     cdbVal_o,
  output logic [ROBsizeLog-1:0]           cdbTag_o,
  output logic [9:0]                      cdbCommands_o,
  output logic [3:0]                      cdbFlags_o,
  output logic [$clog2(NUM_UNITS)-1:0]    cdbUnit_o
);

  localparam int UNIT_W = $clog2(NUM_UNITS);

  logic                  slot_free_s;
  logic                  found_s;
  logic                  grant_s;
  logic [UNIT_W-1:0]     grant_idx_s;
  logic [63:0]           sel_val_s;
  logic [ROBsizeLog-1:0] sel_tag_s;
  logic [9:0]            sel_cmd_s;
  logic [3:0]            sel_flags_s;

`ifdef EXEC_ARB_FIXED_PRI_EN
  // Winner select: scan from the top so the lowest-index valid unit is the last write.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (unitValid_i[i]) begin
        found_s     = 1'b1;
        grant_idx_s = UNIT_W'(i);
      end else begin
        found_s     = found_s;
      end
    end
  end
`else
  localparam logic [UNIT_W:0] NUM_UNITS_W = (UNIT_W + 1)'(NUM_UNITS);

  logic [UNIT_W-1:0] rr_r;
  logic [UNIT_W:0]   scan_sum_s;
  logic [UNIT_W-1:0] scan_idx_s;

  // Winner select: first valid unit scanning rr, rr+1, ... modulo NUM_UNITS.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    scan_sum_s  = '0;
    scan_idx_s  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      // rr and i are both below NUM_UNITS, so one conditional subtract wraps.
      scan_sum_s = {1'b0, rr_r} + (UNIT_W + 1)'(i);
      if (scan_sum_s >= NUM_UNITS_W) begin
        scan_sum_s = scan_sum_s - NUM_UNITS_W;
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[UNIT_W-1:0];
      if (!found_s && unitValid_i[scan_idx_s]) begin
        found_s     = 1'b1;
        grant_idx_s = scan_idx_s;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Round-robin pointer: moves just past the unit that was granted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_r <= '0;
    end else if (grant_s) begin
      if (grant_idx_s == UNIT_W'(NUM_UNITS - 1)) begin
        rr_r <= '0;
      end else begin
        rr_r <= grant_idx_s + UNIT_W'(1);
      end
    end else begin
      rr_r <= rr_r;
    end
  end
`endif

  // The slot can take a new result when empty or when the ROB drains it this cycle.
  assign slot_free_s = ~cdbValid_o | ~robStall_i;
  assign grant_s     = slot_free_s & found_s & ~reset_i;

  // One-hot accept pulse to the winning unit.
  always_comb begin
    canGo_o = '0;
    if (grant_s) begin
      canGo_o[grant_idx_s] = 1'b1;
    end else begin
      canGo_o = '0;
    end
  end

  // Field mux: pick the winning unit's result out of the packed buses.
  always_comb begin
    sel_val_s   = '0;
    sel_tag_s   = '0;
    sel_cmd_s   = '0;
    sel_flags_s = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (grant_idx_s == UNIT_W'(k)) begin
        sel_val_s   = unitVal_i[k*64 +: 64];
        sel_tag_s   = unitTag_i[k*ROBsizeLog +: ROBsizeLog];
        sel_cmd_s   = unitCommands_i[k*10 +: 10];
        sel_flags_s = unitFlags_i[k*4 +: 4];
      end else begin
        sel_val_s   = sel_val_s;
      end
    end
  end

  // CDB slot: load on grant, empty on consume, hold while stalled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cdbValid_o    <= 1'b0;
      cdbVal_o      <= 64'd0;
      cdbTag_o      <= '0;
      cdbCommands_o <= 10'd0;
      cdbFlags_o    <= 4'd0;
      cdbUnit_o     <= '0;
    end else if (grant_s) begin
      cdbValid_o    <= 1'b1;
      cdbVal_o      <= sel_val_s;
      cdbTag_o      <= sel_tag_s;
      cdbCommands_o <= sel_cmd_s;
      cdbFlags_o    <= sel_flags_s;
      cdbUnit_o     <= grant_idx_s;
    end else if (cdbValid_o & ~robStall_i) begin
      cdbValid_o    <= 1'b0;
    end else begin
      cdbValid_o    <= cdbValid_o;
    end
  end

endmodule

// File: tb/tb_exec_complete_arbiter.sv
module tb_exec_complete_arbiter;

  localparam int N  = 4;
  localparam int TW = $clog2(32 + 1);
  localparam int UW = $clog2(N);

  typedef struct packed {
    logic [63:0]   val;
    logic [TW-1:0] tag;
    logic [9:0]    cmd;
    logic [3:0]    flags;
    logic [UW-1:0] unit;
  } item_t;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [N-1:0]      unitValid_i;
  logic [N*64-1:0]   unitVal_i;
  logic [N*TW-1:0]   unitTag_i;
  logic [N*10-1:0]   unitCommands_i;
  logic [N*4-1:0]    unitFlags_i;
  logic [N-1:0]      canGo_o;
  logic              robStall_i;
  logic              cdbValid_o;
  logic [63:0]       cdbVal_o;
  logic [TW-1:0]     cdbTag_o;
  logic [9:0]        cdbCommands_o;
  logic [3:0]        cdbFlags_o;
  logic [UW-1:0]     cdbUnit_o;

  int total = 0;
  int bad   = 0;

  item_t        sb[$];
  logic [N-1:0] go_seen = '0;
  int           m_full  = 0;
  int           m_rr    = 0;
  int           arr_pct = 0;
  int           stall_pct = 0;

  exec_complete_arbiter #(.ROBsize(32), .NUM_UNITS(N)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .unitValid_i(unitValid_i), .unitVal_i(unitVal_i), .unitTag_i(unitTag_i),
    .unitCommands_i(unitCommands_i), .unitFlags_i(unitFlags_i),
    .canGo_o(canGo_o), .robStall_i(robStall_i),
    .cdbValid_o(cdbValid_o), .cdbVal_o(cdbVal_o), .cdbTag_o(cdbTag_o),
    .cdbCommands_o(cdbCommands_o), .cdbFlags_o(cdbFlags_o), .cdbUnit_o(cdbUnit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_unit(input int k, input logic [63:0] v, input logic [TW-1:0] t,
                          input logic [9:0] c, input logic [3:0] f);
    unitValid_i[k]            = 1'b1;
    unitVal_i[k*64 +: 64]     = v;
    unitTag_i[k*TW +: TW]     = t;
    unitCommands_i[k*10 +: 10] = c;
    unitFlags_i[k*4 +: 4]     = f;
  endtask

  // Advance one clock; units react to the canGo they saw, new results may arrive.
  task automatic step();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < N; k++) begin
      if (reset_i) begin
        unitValid_i[k] = 1'b0;
      end else if (unitValid_i[k] && go_seen[k]) begin
        unitValid_i[k] = 1'b0;
      end else if (!unitValid_i[k] && ($urandom_range(99) < arr_pct)) begin
        set_unit(k, {$urandom, $urandom}, TW'($urandom), 10'($urandom), 4'($urandom));
      end
    end
    if (stall_pct > 0) robStall_i = ($urandom_range(99) < stall_pct);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
  endtask

  // Reference model: decides which unit should win and what the CDB will then hold.
  always @(negedge clk_i) begin
    int winner;
    int start;
    int k;
    #1;
    if (reset_i) begin
      chk("canGo_in_reset", 128'(canGo_o), 128'd0);
      m_full = 0;
      m_rr   = 0;
      sb.delete();
    end else begin
      chk("cdb_valid", 128'(cdbValid_o), 128'(m_full));
      winner = -1;
`ifdef EXEC_ARB_FIXED_PRI_EN
      start = 0;
`else
      start = m_rr;
`endif
      if (m_full == 0 || !robStall_i) begin
        for (int i = 0; i < N; i++) begin
          k = (start + i) % N;
          if (winner < 0 && unitValid_i[k]) winner = k;
        end
      end
      chk("canGo", 128'(canGo_o), (winner >= 0) ? (128'd1 << winner) : 128'd0);
      if (winner >= 0) begin
        sb.push_back('{val: unitVal_i[winner*64 +: 64], tag: unitTag_i[winner*TW +: TW],
                       cmd: unitCommands_i[winner*10 +: 10], flags: unitFlags_i[winner*4 +: 4],
                       unit: UW'(winner)});
        m_rr   = (winner + 1) % N;
        m_full = 1;
      end else if (m_full != 0 && !robStall_i) begin
        m_full = 0;
      end
    end
    go_seen = canGo_o;
  end

  // Monitor: the CDB contents must match the oldest predicted result until it is consumed.
  always @(negedge clk_i) begin
    item_t act;
    if (!reset_i && cdbValid_o) begin
      act = '{val: cdbVal_o, tag: cdbTag_o, cmd: cdbCommands_o, flags: cdbFlags_o, unit: cdbUnit_o};
      if (sb.size() == 0) begin
        chk("cdb_unexpected", 128'(act), 128'd0);
      end else begin
        chk("cdb_data", 128'(act), 128'(sb[0]));
        if (!robStall_i) void'(sb.pop_front());
      end
    end
  end

  logic [N-1:0] exp2 [5];
  logic [N-1:0] exp4a, exp4b;

  initial begin
`ifdef EXEC_ARB_FIXED_PRI_EN
    exp2  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    exp4a = 4'b0001;
    exp4b = 4'b1000;
`else
    exp2  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp4a = 4'b1000;
    exp4b = 4'b0001;
`endif
    reset_i = 1'b1; robStall_i = 1'b0;
    unitValid_i = '0; unitVal_i = '0; unitTag_i = '0; unitCommands_i = '0; unitFlags_i = '0;
    repeat (3) step();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("reset_cdb", 128'({cdbValid_o, cdbVal_o, cdbTag_o, cdbCommands_o, cdbFlags_o, cdbUnit_o}), 128'd0);
    chk("reset_canGo", 128'(canGo_o), 128'd0);

    // Single result from unit 2.
    step();
    set_unit(2, 64'd15, TW'(3), 10'd10, 4'd0);
    @(negedge clk_i);
    chk("t1_canGo", 128'(canGo_o), 128'b0100);
    step();
    @(negedge clk_i);
    chk("t1_cdb", 128'({cdbValid_o, cdbVal_o, cdbTag_o, cdbUnit_o}), 128'({1'b1, 64'd15, TW'(3), UW'(2)}));

    // All units persistently valid: grants rotate, CDB stays full.
    do_reset();
    arr_pct = 100;
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk_i);
      chk("t2_canGo", 128'(canGo_o), 128'(exp2[c]));
      if (c > 0) chk("t2_cdbValid", 128'(cdbValid_o), 128'd1);
    end
    arr_pct = 0;

    // Stall holds the slot; unit 1 waits and then loads.
    do_reset();
    step();
    set_unit(0, 64'hA5, TW'(5), 10'd1, 4'd2);
    @(negedge clk_i);
    step();
    robStall_i = 1'b1;
    set_unit(1, 64'd77, TW'(9), 10'd3, 4'd4);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      chk("t3_stall_canGo", 128'(canGo_o), 128'd0);
      chk("t3_stall_cdb", 128'({cdbValid_o, cdbTag_o}), 128'({1'b1, TW'(5)}));
      step();
    end
    robStall_i = 1'b0;
    @(negedge clk_i);
    chk("t3_release_canGo", 128'(canGo_o), 128'b0010);
    step();
    @(negedge clk_i);
    chk("t3_loaded", 128'({cdbTag_o, cdbUnit_o}), 128'({TW'(9), UW'(1)}));

    // Pointer at 3 with units 0 and 3 valid.
    do_reset();
    step();
    set_unit(2, 64'd1, TW'(1), 10'd0, 4'd0);
    @(negedge clk_i);
    step();
    set_unit(0, 64'd100, TW'(10), 10'd5, 4'd1);
    set_unit(3, 64'd300, TW'(30), 10'd6, 4'd3);
    @(negedge clk_i);
    chk("t4_first", 128'(canGo_o), 128'(exp4a));
    step();
    @(negedge clk_i);
    chk("t4_second", 128'(canGo_o), 128'(exp4b));

    // Reset while the slot is full and unit 1 is waiting.
    step();
    set_unit(1, 64'd11, TW'(11), 10'd7, 4'd5);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("t5_canGo_reset", 128'(canGo_o), 128'd0);
    step();
    reset_i = 1'b0;
    @(negedge clk_i);
    chk("t5_after", 128'({cdbValid_o, canGo_o}), 128'd0);
    step();
    set_unit(0, 64'd5, TW'(2), 10'd0, 4'd0);
    set_unit(3, 64'd6, TW'(4), 10'd0, 4'd0);
    @(negedge clk_i);
    chk("t5_rr_zero", 128'(canGo_o), 128'b0001);

    // Idle after consume.
    do_reset();
    step();
    set_unit(1, 64'd42, TW'(7), 10'd2, 4'd1);
    @(negedge clk_i);
    step();
    @(negedge clk_i);
    for (int c = 0; c < 5; c++) begin
      step();
      @(negedge clk_i);
      chk("t6_idle", 128'({cdbValid_o, canGo_o}), 128'd0);
    end

    // Random traffic with backpressure and occasional reset.
    arr_pct   = 45;
    stall_pct = 30;
    for (int c = 0; c < 3000; c++) begin
      step();
      reset_i = ($urandom_range(299) == 0);
    end
    reset_i   = 1'b0;
    stall_pct = 0;
    robStall_i = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
